// File: rtl/program_counter_unit_pkg.sv
// Shared types for the FRANK program counter unit: sequencer state encoding,
// the control-flow request bundle and the clock-edge selector macro.
`ifndef PROGRAM_COUNTER_UNIT_PKG_SV
`define PROGRAM_COUNTER_UNIT_PKG_SV

// Clock-edge selector used by every sequential block of this unit.
`define PCU_CLK_EDGE posedge

package program_counter_unit_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        RET_WAIT = 2'd1,
        HALT     = 2'd2,
        FAULT    = 2'd3
    } pcu_state_t;

    // Control-flow requests in decreasing priority order (halt highest).
    typedef struct packed {
        logic halt;
        logic ret;
        logic call;
        logic jmp;
        logic brz;
        logic brc;
    } pcu_req_t;

endpackage

`endif

// File: rtl/program_counter_unit_pc_next_mux.sv
// Next-PC selector: resolves the request priority and returns the next PC
// together with the qualified action taken.
// Ports:
//   pc, target        current PC and jump/branch/call destination
//   req               request bundle (halt > ret > call > jmp > brz > brc)
//   zero, carry       ALU flags for the conditional branches
//   full, empty       call-depth status
//   next_pc           PC to load when the sequencer advances
//   take_halt/call/ret/ovf/unf  resolved action qualifiers
module program_counter_unit_pc_next_mux
    import program_counter_unit_pkg::*;
#(
    parameter int unsigned data_width = 8
) (
    input  logic [data_width-1:0] pc,
    input  logic [data_width-1:0] target,
    input  pcu_req_t              req,
    input  logic                  zero,
    input  logic                  carry,
    input  logic                  full,
    input  logic                  empty,
    output logic [data_width-1:0] next_pc,
    output logic                  take_halt,
    output logic                  take_call,
    output logic                  take_ret,
    output logic                  take_ovf,
    output logic                  take_unf
);

    logic [data_width-1:0] pc_inc;

    // Plain increment wraps naturally at the data width.
    assign pc_inc = pc + data_width'(1);

    // Priority resolution.
    always_comb begin
        next_pc   = pc_inc;
        take_halt = 1'b0;
        take_call = 1'b0;
        take_ret  = 1'b0;
        take_ovf  = 1'b0;
        take_unf  = 1'b0;
        if (req.halt) begin
            next_pc   = pc;
            take_halt = 1'b1;
        end else if (req.ret) begin
            next_pc = pc;
            if (empty) begin
                take_unf = 1'b1;
            end else begin
                take_ret = 1'b1;
            end
        end else if (req.call) begin
            if (full) begin
                next_pc  = pc;
                take_ovf = 1'b1;
            end else begin
                next_pc   = target;
                take_call = 1'b1;
            end
        end else if (req.jmp) begin
            next_pc = target;
        end else if (req.brz) begin
            next_pc = zero ? target : pc_inc;
        end else if (req.brc) begin
            next_pc = carry ? target : pc_inc;
        end
    end

endmodule

// File: rtl/program_counter_unit.sv
// Program counter and control-flow sequencer for the FRANK processor.
// Drives the instruction stack's PC/call/rtrn inputs and reloads the PC from
// the stack on return. Tracks call depth to flag overflow/underflow.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_en                     advance enable in RUN
//   i_halt..i_brc            control-flow requests
//   i_zero, i_carry          ALU flags
//   i_target                 jump/branch/call destination
//   i_Stack                  return address from the stack
//   o_PC                     current PC
//   o_call, o_rtrn           stack push/pop strobes (combinational)
//   o_busy, o_halted         state decode
//   o_overflow, o_underflow  sticky depth faults
module program_counter_unit
    import program_counter_unit_pkg::*;
#(
    parameter int unsigned data_width = 8,
    parameter int unsigned addr_width = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_halt,
    input  logic                  i_call,
    input  logic                  i_ret,
    input  logic                  i_jmp,
    input  logic                  i_brz,
    input  logic                  i_brc,
    input  logic                  i_zero,
    input  logic                  i_carry,
    input  logic [data_width-1:0] i_target,
    input  logic [data_width-1:0] i_Stack,
    output logic [data_width-1:0] o_PC,
    output logic                  o_call,
    output logic                  o_rtrn,
    output logic                  o_busy,
    output logic                  o_halted,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int unsigned          DEPTH_W   = addr_width + 1;
    localparam logic [DEPTH_W-1:0]   DEPTH_MAX = DEPTH_W'(2 ** addr_width);

    pcu_state_t            state;
    pcu_state_t            state_next;
    pcu_req_t              req;
    logic [DEPTH_W-1:0]    depth;
    logic [data_width-1:0] next_pc;
    logic                  take_halt;
    logic                  take_call;
    logic                  take_ret;
    logic                  take_ovf;
    logic                  take_unf;
    logic                  advance;

    assign req = '{halt: i_halt, ret: i_ret, call: i_call,
                   jmp: i_jmp, brz: i_brz, brc: i_brc};

    // Requests only act in RUN with enable; reset masks them so no strobe
    // reaches the stack during a reset cycle.
    assign advance = (state == RUN) && i_en && !rst;

    program_counter_unit_pc_next_mux #(
        .data_width (data_width)
    ) u_pc_next_mux (
        .pc        (o_PC),
        .target    (i_target),
        .req       (req),
        .zero      (i_zero),
        .carry     (i_carry),
        .full      (depth == DEPTH_MAX),
        .empty     (depth == '0),
        .next_pc   (next_pc),
        .take_halt (take_halt),
        .take_call (take_call),
        .take_ret  (take_ret),
        .take_ovf  (take_ovf),
        .take_unf  (take_unf)
    );

    // State register.
    always_ff @(`PCU_CLK_EDGE clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; HALT and FAULT are terminal until reset.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (advance) begin
                    if (take_halt) begin
                        state_next = HALT;
                    end else if (take_ret) begin
                        state_next = RET_WAIT;
                    end else if (take_ovf || take_unf) begin
                        state_next = FAULT;
                    end
                end
            end
            RET_WAIT: state_next = RUN;
            default:  state_next = state;
        endcase
    end

    // Output decode.
    always_comb begin
        o_call   = advance && take_call;
        o_rtrn   = advance && take_ret;
        o_busy   = (state != RUN);
        o_halted = (state == HALT);
    end

    // PC, depth counter and sticky fault flags.
    always_ff @(`PCU_CLK_EDGE clk) begin
        if (rst) begin
            o_PC        <= '0;
            depth       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else if (state == RET_WAIT) begin
            // Stack read data is valid one cycle after the pop strobe.
            o_PC <= i_Stack;
        end else if (advance) begin
            o_PC <= next_pc;
            if (take_call) begin
                depth <= depth + DEPTH_W'(1);
            end else if (take_ret) begin
                depth <= depth - DEPTH_W'(1);
            end
            if (take_ovf) begin
                o_overflow <= 1'b1;
            end
            if (take_unf) begin
                o_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_program_counter_unit.sv
// Scoreboard bench for program_counter_unit: a stack-based reference model
// predicts each cycle's outputs; a negedge monitor pops and compares.
module tb_program_counter_unit;

    localparam logic [5:0] R_NONE = 6'b000000;
    localparam logic [5:0] R_HALT = 6'b100000;
    localparam logic [5:0] R_RET  = 6'b010000;
    localparam logic [5:0] R_CALL = 6'b001000;
    localparam logic [5:0] R_JMP  = 6'b000100;
    localparam logic [5:0] R_BRZ  = 6'b000010;
    localparam logic [5:0] R_BRC  = 6'b000001;
    localparam int          MAX_DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_en, i_halt, i_call, i_ret, i_jmp, i_brz, i_brc, i_zero, i_carry;
    logic [7:0] i_target, i_Stack;
    logic [7:0] o_PC;
    logic       o_call, o_rtrn, o_busy, o_halted, o_overflow, o_underflow;

    program_counter_unit #(.data_width(8), .addr_width(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_en        (i_en),
        .i_halt      (i_halt),
        .i_call      (i_call),
        .i_ret       (i_ret),
        .i_jmp       (i_jmp),
        .i_brz       (i_brz),
        .i_brc       (i_brc),
        .i_zero      (i_zero),
        .i_carry     (i_carry),
        .i_target    (i_target),
        .i_Stack     (i_Stack),
        .o_PC        (o_PC),
        .o_call      (o_call),
        .o_rtrn      (o_rtrn),
        .o_busy      (o_busy),
        .o_halted    (o_halted),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int  pc;
        bit  call, rtrn, busy, halted, ovf, unf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: the return stack is a real queue of return addresses.
    logic [7:0] m_pc;
    logic [7:0] m_stack[$];
    logic [7:0] m_ret_val;
    bit         m_wait, m_halt, m_fault, m_ovf, m_unf;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("o_PC",        int'(o_PC),        e.pc);
            chk("o_call",      int'(o_call),      int'(e.call));
            chk("o_rtrn",      int'(o_rtrn),      int'(e.rtrn));
            chk("o_busy",      int'(o_busy),      int'(e.busy));
            chk("o_halted",    int'(o_halted),    int'(e.halted));
            chk("o_overflow",  int'(o_overflow),  int'(e.ovf));
            chk("o_underflow", int'(o_underflow), int'(e.unf));
        end
    end

    task automatic model_reset();
        m_pc    = 8'h00;
        m_stack.delete();
        m_wait  = 1'b0;
        m_halt  = 1'b0;
        m_fault = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // One clock: drive, predict, push, advance the model across the edge.
    task automatic step(input bit rs, input bit en, input logic [5:0] req,
                        input bit z, input bit c, input logic [7:0] tgt);
        exp_t e;
        bit   running, act, h, r, cl, j, bz, bc;
        {h, r, cl, j, bz, bc} = req;
        rst      = rs;
        i_en     = en;
        {i_halt, i_ret, i_call, i_jmp, i_brz, i_brc} = req;
        i_zero   = z;
        i_carry  = c;
        i_target = tgt;
        i_Stack  = m_wait ? m_ret_val : 8'($urandom);

        running  = !m_wait && !m_halt && !m_fault;
        act      = running && en && !rs;
        e.pc     = int'(m_pc);
        e.call   = act && !h && !r && cl && (m_stack.size() < MAX_DEPTH);
        e.rtrn   = act && !h && r && (m_stack.size() > 0);
        e.busy   = !running;
        e.halted = m_halt;
        e.ovf    = m_ovf;
        e.unf    = m_unf;
        sb.push_back(e);

        @(posedge clk);
        if (rs) begin
            model_reset();
        end else if (m_wait) begin
            m_pc   = m_ret_val;
            m_wait = 1'b0;
        end else if (act) begin
            if (h) begin
                m_halt = 1'b1;
            end else if (r) begin
                if (m_stack.size() == 0) begin
                    m_unf   = 1'b1;
                    m_fault = 1'b1;
                end else begin
                    m_ret_val = m_stack.pop_back();
                    m_wait    = 1'b1;
                end
            end else if (cl) begin
                if (m_stack.size() == MAX_DEPTH) begin
                    m_ovf   = 1'b1;
                    m_fault = 1'b1;
                end else begin
                    m_stack.push_back(m_pc + 8'd1);
                    m_pc = tgt;
                end
            end else if (j) begin
                m_pc = tgt;
            end else if (bz) begin
                m_pc = z ? tgt : m_pc + 8'd1;
            end else if (bc) begin
                m_pc = c ? tgt : m_pc + 8'd1;
            end else begin
                m_pc = m_pc + 8'd1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, R_NONE, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, R_NONE, 1'b0, 1'b0, 8'h00);
    endtask

    function automatic logic [5:0] rand_req();
        logic [5:0] q;
        q = R_NONE;
        if ($urandom_range(0, 63) == 0) q = q | R_HALT;
        if ($urandom_range(0, 5)  == 0) q = q | R_RET;
        if ($urandom_range(0, 4)  == 0) q = q | R_CALL;
        if ($urandom_range(0, 5)  == 0) q = q | R_JMP;
        if ($urandom_range(0, 5)  == 0) q = q | R_BRZ;
        if ($urandom_range(0, 5)  == 0) q = q | R_BRC;
        return q;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; i_en = 1'b0;
        {i_halt, i_ret, i_call, i_jmp, i_brz, i_brc} = R_NONE;
        i_zero = 1'b0; i_carry = 1'b0; i_target = 8'h00; i_Stack = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Increment from reset, call at PC=3, return via the stack.
        idle(3);
        step(1'b0, 1'b1, R_CALL, 1'b0, 1'b0, 8'h40);
        idle(1);
        step(1'b0, 1'b1, R_RET, 1'b0, 1'b0, 8'h00);
        idle(3);

        // Branches, jump+call priority, enable low.
        step(1'b0, 1'b1, R_JMP, 1'b0, 1'b0, 8'h10);
        step(1'b0, 1'b1, R_BRZ, 1'b0, 1'b0, 8'h80);
        step(1'b0, 1'b1, R_JMP, 1'b0, 1'b0, 8'h10);
        step(1'b0, 1'b1, R_BRZ, 1'b1, 1'b0, 8'h80);
        step(1'b0, 1'b1, R_BRC, 1'b0, 1'b0, 8'h55);
        step(1'b0, 1'b1, R_BRC, 1'b0, 1'b1, 8'h55);
        step(1'b0, 1'b1, R_BRZ | R_BRC, 1'b0, 1'b1, 8'h66);
        step(1'b0, 1'b1, R_JMP | R_CALL, 1'b0, 1'b0, 8'h22);
        step(1'b0, 1'b0, R_CALL, 1'b0, 1'b0, 8'h99);
        step(1'b0, 1'b0, R_RET, 1'b0, 1'b0, 8'h99);
        idle(1);

        // Fill the call stack, then overflow into FAULT.
        do_reset();
        for (int k = 0; k < 17; k++) step(1'b0, 1'b1, R_CALL, 1'b0, 1'b0, 8'($urandom));
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, rand_req(), 1'b1, 1'b1, 8'($urandom));
        do_reset();
        idle(1);

        // Return with empty stack.
        do_reset();
        step(1'b0, 1'b1, R_RET, 1'b0, 1'b0, 8'h00);
        idle(2);

        // PC wrap.
        do_reset();
        step(1'b0, 1'b1, R_JMP, 1'b0, 1'b0, 8'hFF);
        idle(2);

        // Halt at PC=7 with requests afterwards.
        step(1'b0, 1'b1, R_JMP, 1'b0, 1'b0, 8'h07);
        step(1'b0, 1'b1, R_HALT, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, rand_req() | R_CALL, 1'b1, 1'b1, 8'($urandom));

        // Reset during the return wait cycle.
        do_reset();
        step(1'b0, 1'b1, R_CALL, 1'b0, 1'b0, 8'h30);
        step(1'b0, 1'b1, R_RET, 1'b0, 1'b0, 8'h00);
        do_reset();
        idle(2);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 7) != 0, rand_req(),
                 1'($urandom), 1'($urandom), 8'($urandom));
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_counter_unit.md
Name: program_counter_unit

Overview:
Program counter and control-flow sequencer for the FRANK processor. It sits directly upstream of the instruction stack: it drives that stack's PC input, call strobe and rtrn strobe, and it consumes the stack's output to reload the PC on return. It resolves increment, jump, conditional branch, call, return and halt. It also tracks stack depth so that overflow and underflow are caught before the stack wraps.

Parameters:
- data_width, 8: PC width and instruction-address width; matches the stack data width.
- addr_width, 4: stack address width; maximum call depth is 2**addr_width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i_en  input  1  advance enable; when low, the PC holds in RUN.
- i_halt  input  1  halt request.
- i_call  input  1  call request to i_target.
- i_ret  input  1  return request.
- i_jmp  input  1  unconditional jump to i_target.
- i_brz  input  1  branch to i_target if i_zero is set.
- i_brc  input  1  branch to i_target if i_carry is set.
- i_zero  input  1  ALU zero flag.
- i_carry  input  1  ALU carry flag.
- i_target  input  data_width  jump, branch or call destination.
- i_Stack  input  data_width  return address from the instruction stack.
- o_PC  output  data_width  current PC; also feeds the stack's PC input.
- o_call  output  1  stack push strobe (combinational).
- o_rtrn  output  1  stack pop strobe (combinational).
- o_busy  output  1  high when the state is not RUN.
- o_halted  output  1  high in HALT.
- o_overflow  output  1  sticky; set by a call at full depth.
- o_underflow  output  1  sticky; set by a return at zero depth.

Behaviour:
- Reset (synchronous, active-high): o_PC=0, depth=0, state=RUN, o_overflow=0, o_underflow=0. All other outputs decode to 0.
- depth counter: addr_width+1 bits. "full" means depth==2**addr_width; "empty" means depth==0.
- States:
  - RUN: normal sequencing.
  - RET_WAIT: one cycle spent waiting for the stack's registered read.
  - HALT: terminal until rst.
  - FAULT: terminal until rst.
- RUN with i_en=1: fixed priority halt > ret > call > jmp > brz > brc > increment.
  - halt: go to HALT; PC holds.
  - ret, not empty: o_rtrn=1 this cycle; depth-1; go to RET_WAIT; PC holds.
  - ret, empty: o_rtrn=0; set o_underflow; go to FAULT.
  - call, not full: o_call=1 this cycle, so the stack stores o_PC+1 at this edge; PC<=i_target; depth+1.
  - call, full: o_call=0; set o_overflow; go to FAULT.
  - jmp: PC<=i_target.
  - brz: PC<=i_target if i_zero, else PC+1. brc behaves the same way using i_carry.
  - none of the above: PC<=PC+1, wrapping modulo 2**data_width (all-ones goes to 0).
- RUN with i_en=0: everything holds; o_call=o_rtrn=0 regardless of requests.
- RET_WAIT: PC<=i_Stack, go to RUN. This ignores i_en and all requests. Return latency is 2 cycles from the ret edge to the target PC.
- HALT and FAULT: PC, depth and flags hold; o_call=o_rtrn=0; only rst exits.
- o_call and o_rtrn are never high in the same cycle. They are only high in RUN with i_en=1.
- Reset mid-RET_WAIT: go to RUN with PC=0; the pending return is discarded.
- Requests asserted outside RUN are dropped, not queued.

Decomposition:
- Shared package holds:
  - state encoding constants RUN, RET_WAIT, HALT, FAULT;
  - the edge-select macro already used in the codebase.
- One natural sub-module: pc_next_mux. It is combinational and takes PC, target, the request vector and the flags. It returns next_pc, plus a take_call or take_ret qualifier after priority resolution.
- The top level keeps the state register, depth counter and sticky flags.

Test Plan:
- Reset, then i_en=1 for 5 cycles with no requests -> o_PC steps 0,1,2,3,4,5; o_call=o_rtrn=0.
- At PC=3: call with i_target=0x40 -> o_call=1 in that cycle; next o_PC=0x40. Later ret -> o_rtrn=1, o_busy=1 for one cycle; with the stack returning 0x04, o_PC=0x04 two edges after ret.
- PC=0x10: brz with i_zero=0 gives 0x11; brz with i_zero=1 and i_target=0x80 gives 0x80. jmp and call asserted together -> call wins; o_call=1.
- Issue 16 calls (addr_width=4), then a 17th call -> o_call=0 on the 17th; o_overflow=1; FAULT; PC frozen. rst clears everything.
- Ret right after reset -> o_rtrn=0, o_underflow=1, o_busy=1. Separately: PC=0xFF with increment -> 0x00.
- Halt at PC=7 -> o_halted=1; PC stays 7 for 10 cycles despite requests. rst asserted during RET_WAIT -> o_PC=0, state RUN next cycle.
